// File: rtl/sdp_ram_if.sv
// Write/read bus of the simple dual-port RAM.
// Master drives requests; slave returns read data and valid.
interface sdp_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NUM_BYTES-1:0]  wr_be;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be,
    output rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be,
    input  rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/sdp_ram_sync_be.sv
// Simple dual-port sync RAM with byte enables,
// optional output register and selectable read-during-write.
module sdp_ram_sync_be #(
  parameter int          DATA_WIDTH = 32,
  parameter int          BYTE_WIDTH = 8,
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int          OUT_REG    = 0,
  parameter int          RDW_MODE   = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  sdp_ram_if.slave bus
);
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  v1;
  logic [DATA_WIDTH-1:0] d1;

  assign wr_ok = rst_n & bus.wr_en
               & (32'(bus.wr_addr) < RAM_DEPTH);
  assign rd_ok = 32'(bus.rd_addr) < RAM_DEPTH;

  // No reset on the array so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.wr_be[i])
          mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH]
            <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      rd_word = mem[bus.rd_addr];
      if (RDW_MODE == 1 && wr_ok
          && bus.wr_addr == bus.rd_addr) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (bus.wr_be[i])
            rd_word[i*BYTE_WIDTH +: BYTE_WIDTH]
              = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= bus.rd_en;
      if (bus.rd_en)
        d1 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1)
            d2 <= d1;
        end
      end

      assign bus.rd_valid = v2;
      assign bus.rd_data  = d2;
    end else begin : g_noreg
      assign bus.rd_valid = v1;
      assign bus.rd_data  = d1;
    end
  endgenerate
endmodule
